// File: rtl/recon_frame_builder.sv
// recon_frame_builder: builds 512-bit reconfiguration frames from a command and
// an optional payload stream. The 46-byte Eth/IP/RMT header and the 10-byte recon
// header take output bytes 0..55. Payload is shifted up by 56 bytes, so each output
// beat holds the previous payload beat's bytes 8..63 (the residue) followed by the
// current payload beat's bytes 0..7.
//
// Handshakes (all streams): a transfer happens on a rising clk edge where
// valid && ready. A source holds valid and its payload steady until that edge.
// The frame output is one register stage. Its contents stay put while
// m_axis_tvalid && !m_axis_tready. s_axis_tready is derived combinationally from
// m_axis_tready, so there is no skid buffer.
module recon_frame_builder #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [367:0]          s_axis_cmd_hdr,
  input  logic [1:0]            s_axis_cmd_func,
  input  logic                  s_axis_cmd_size_valid,
  input  logic [ADDR_WIDTH-1:0] s_axis_cmd_addr,
  input  logic [7:0]            s_axis_cmd_id,
  input  logic [31:0]           s_axis_cmd_size,
  input  logic                  s_axis_cmd_payload,
  input  logic                  s_axis_cmd_valid,
  output logic                  s_axis_cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  len_error,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_FLUSH} state_t;

  state_t state, state_nxt;

  // Latched command fields
  logic [367:0]          hdr_q;
  logic [1:0]            func_q;
  logic                  size_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            id_q;
  logic [31:0]           size_q;
  logic                  payload_q;

  logic [31:0]            byte_cnt;
  logic [DATA_WIDTH-65:0] residue;
  logic [6:0]             flush_bytes;

  logic [79:0]            recon;
  logic                   out_free;
  logic                   cmd_fire;
  logic                   pay_fire;
  logic [6:0]             in_k;
  logic                   short_tail;
  logic [KEEP_WIDTH-1:0]  beat_keep;
  logic                   beat_last;
  state_t                 beat_next;

  logic                   emit;
  logic [DATA_WIDTH-1:0]  emit_data;
  logic [KEEP_WIDTH-1:0]  emit_keep;
  logic                   emit_last;

  // Mask with the low n bits set, n in 0..64
  function automatic logic [KEEP_WIDTH-1:0] low_mask(input logic [6:0] n);
    if (n >= 7'd64) low_mask = '1;
    else            low_mask = (KEEP_WIDTH'(1) << n) - KEEP_WIDTH'(1);
  endfunction

  assign recon = {3'b000, size_q, id_q, addr_q, size_valid_q, func_q};

  assign out_free         = !m_axis_tvalid || m_axis_tready;
  assign s_axis_cmd_ready = (state == S_IDLE) && !rst;
  assign s_axis_tready    = ((state == S_FIRST) || (state == S_BODY)) && payload_q && out_free;
  assign cmd_fire         = s_axis_cmd_valid && s_axis_cmd_ready;
  assign pay_fire         = s_axis_tvalid && s_axis_tready;
  assign busy             = (state != S_IDLE);
  assign dbg_state        = state;

  // Popcount of the incoming tkeep and the tail rule for a payload beat
  always_comb begin
    in_k = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      in_k = in_k + 7'(s_axis_tkeep[i]);
    end
    short_tail = s_axis_tlast && (in_k <= 7'd8);
    beat_keep  = short_tail ? low_mask(7'd56 + in_k) : '1;
    beat_last  = short_tail;
    if (!s_axis_tlast)     beat_next = S_BODY;
    else if (in_k > 7'd8)  beat_next = S_FLUSH;
    else                   beat_next = S_IDLE;
  end

  // Next-state and the beat to load into the output register
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_data = '0;
    emit_keep = '0;
    emit_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_fire) state_nxt = S_FIRST;
      end
      S_FIRST: begin
        if (!payload_q) begin
          if (out_free) begin
            emit      = 1'b1;
            emit_data = {64'b0, recon, hdr_q};
            emit_keep = low_mask(7'd56);
            emit_last = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (pay_fire) begin
          emit      = 1'b1;
          emit_data = {s_axis_tdata[63:0], recon, hdr_q};
          emit_keep = beat_keep;
          emit_last = beat_last;
          state_nxt = beat_next;
        end
      end
      S_BODY: begin
        if (pay_fire) begin
          emit      = 1'b1;
          emit_data = {s_axis_tdata[63:0], residue};
          emit_keep = beat_keep;
          emit_last = beat_last;
          state_nxt = beat_next;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_data = {64'b0, residue};
          emit_keep = low_mask(flush_bytes);
          emit_last = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Command capture on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q        <= '0;
      func_q       <= '0;
      size_valid_q <= 1'b0;
      addr_q       <= '0;
      id_q         <= '0;
      size_q       <= '0;
      payload_q    <= 1'b0;
    end else if (cmd_fire) begin
      hdr_q        <= s_axis_cmd_hdr;
      func_q       <= s_axis_cmd_func;
      size_valid_q <= s_axis_cmd_size_valid;
      addr_q       <= s_axis_cmd_addr;
      id_q         <= s_axis_cmd_id;
      size_q       <= s_axis_cmd_size;
      payload_q    <= s_axis_cmd_payload;
    end
  end

  // Byte counter, residue of the previous payload beat, and flush length
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      residue     <= '0;
      flush_bytes <= '0;
    end else if (cmd_fire) begin
      byte_cnt <= '0;
    end else if (pay_fire) begin
      byte_cnt <= byte_cnt + 32'(in_k);
      residue  <= s_axis_tdata[DATA_WIDTH-1:64];
      if (s_axis_tlast) flush_bytes <= in_k - 7'd8;
    end
  end

  // Output register: loads only when free so stalled beats stay stable
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_free) begin
      m_axis_tvalid <= emit;
      if (emit) begin
        m_axis_tdata <= emit_data;
        m_axis_tkeep <= emit_keep;
        m_axis_tlast <= emit_last;
      end
    end
  end

  // Length check pulse at the tlast payload beat
  always_ff @(posedge clk) begin
    if (rst) len_error <= 1'b0;
    else     len_error <= pay_fire && s_axis_tlast && size_valid_q &&
                          ((byte_cnt + 32'(in_k)) != size_q);
  end

endmodule

// File: doc/recon_frame_builder.md
# recon_frame_builder

Transmit-side counterpart of the reconfiguration frame receiver. It accepts a reconfiguration command (function type, bitstream address, ID and size) and an optional payload stream, then emits complete 512-bit AXI-stream frames. Each frame carries a 46-byte Ethernet/IP/RMT header, the 10-byte recon header at byte offset 46, and the payload realigned to follow it. It sits between the DMA read data path (or host command logic) and the MAC transmit FIFO.

## Interface
- DATA_WIDTH, 512, stream width in bits; only 512 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 34, bitstream address width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_cmd_hdr  in  368  Eth/IP/RMT header bytes 0..45; byte 0 sits in bits [7:0].
- s_axis_cmd_func  in  2  func_type: 00 = write, 01 = read.
- s_axis_cmd_size_valid  in  1  recon header bit 2.
- s_axis_cmd_addr  in  ADDR_WIDTH  bitstream address.
- s_axis_cmd_id  in  8  bitstream ID.
- s_axis_cmd_size  in  32  bitstream size in bytes.
- s_axis_cmd_payload  in  1  1 = payload stream follows; 0 = header-only frame.
- s_axis_cmd_valid / s_axis_cmd_ready  in / out  1  command handshake.
- s_axis_tdata / tkeep / tvalid / tlast  in  512/64/1/1  payload stream.
- s_axis_tready  out  1  payload ready.
- m_axis_tdata / tkeep / tvalid / tlast  out  512/64/1/1  frame stream.
- m_axis_tready  in  1  frame ready.
- busy  out  1  high in any state other than IDLE.
- len_error  out  1  one-cycle pulse when the payload byte count differs from cmd_size.

## Operation
- **Recon header** (80 bits, output bytes 46..55):
  - [1:0] func
  - [2] size_valid
  - [36:3] addr
  - [44:37] id
  - [76:45] size
  - [79:77] = 0
- **Payload alignment.** Payload tkeep is contiguous from bit 0. Only the tlast beat may be partial; its valid-byte count is k, with 1 ≤ k ≤ 64.
  - Output beat 0 = header bytes 0..55, plus payload beat 0 bytes 0..7 in output bytes 56..63.
  - Output beat n (n ≥ 1) = payload beat n−1 bytes 8..63 in output bytes 0..55, plus payload beat n bytes 0..7 in output bytes 56..63.
  - A 56-byte residue register holds the previous payload beat's bytes 8..63.
- **Last payload beat with k bytes:**
  - k ≤ 8: the output beat that carries it is last; tkeep = low (56+k) bits set.
  - k > 8: that output beat is full (tkeep all ones, tlast = 0). A FLUSH beat follows with the residue's k−8 bytes, tkeep = low (k−8) bits, tlast = 1.
- **Header-only frame:** one beat, tkeep = low 56 bits, tlast = 1. No payload is consumed.
- **State machine:**
  - IDLE: cmd_ready = 1. On cmd handshake, latch all command fields, clear the byte counter, go to FIRST.
  - FIRST: when the output register is free, emit beat 0.
    - Header-only: emit and go to IDLE.
    - With payload: requires s_axis_tvalid. Next state is BODY, FLUSH (tlast with k > 8) or IDLE (tlast with k ≤ 8).
  - BODY: on each accepted payload beat, emit the realigned beat. On tlast, go to FLUSH or IDLE by the k rule.
  - FLUSH: emit the residue beat with tlast, then go to IDLE. No payload is consumed.
- **Output register free** = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = (state is FIRST or BODY) && cmd_payload && free.
- **Byte counter:** 32 bits; adds popcount(tkeep) on every accepted payload beat.
  - At the tlast beat, len_error pulses if size_valid = 1 and (count + k) ≠ cmd_size.
  - The frame is still sent unchanged.
- **Payload without a command:** stalled, because s_axis_tready = 0 in IDLE.

## Timing
- Reset values:
  - m_axis_tvalid = 0, tlast = 0, tdata = 0, tkeep = 0.
  - s_axis_tready = 0, cmd_ready = 0 during reset, busy = 0, len_error = 0.
  - State = IDLE.
- Reset mid-frame: the output register is cleared. No tlast is emitted for the aborted frame, and it is not resumed.
- Latency: with the command accepted at edge T and payload beat 0 valid, the first beat is valid after edge T+1. Steady state is one beat per cycle.
- Output register: m_axis data and control stay stable while tvalid && !tready.
- Frame gap: at least one idle cycle between a frame's tlast beat and the next frame's beat 0, because the command is accepted only in IDLE.
- Input backpressure: s_axis_tready follows m_axis_tready combinationally, with no skid buffer.

## Test plan
- Header-only read (func = 01, addr = 0x2_0000_1000, id = 5, size = 0x1000) -> one beat; tkeep = 0x00FF_FFFF_FFFF_FFFF; tlast = 1; bytes 46..55 decode to the command fields.
- 8-byte payload (a single beat with tkeep = 0xFF) -> one beat; tkeep all ones; tlast = 1.
- 64-byte payload in one beat -> beat 0 full; a FLUSH beat with 56 bytes (tkeep = 0x00FF_FFFF_FFFF_FFFF), tlast = 1, data = payload bytes 8..63.
- 130-byte payload (beats of 64, 64, 2 bytes) -> 3 beats with 64, 64, 58 valid bytes; the byte sequence matches the payload exactly; len_error = 0 for size = 130.
- Random m_axis_tready (50% duty) on the 130-byte frame -> identical output; no beat dropped or duplicated; data held while stalled.
- size = 100 with a 130-byte payload -> a single len_error pulse at the tlast beat. Separately, reset asserted at beat 1 -> m_axis_tvalid = 0 after the next edge; the next command produces a clean frame.
